dmem_arbiter: RTL

- Shares the single data memory port between the pipeline MEM stage and an external debug/loader port.
- Sits between the EXE/MEM register outputs (a, di, mwmem, mm2reg) and datamem.
- The pipeline has priority. A starvation guard forces a debug access after MAX_WAIT blocked cycles and stalls the pipeline for that one cycle.

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: MEM-stage request, datamem port, debug port and stall outputs.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
);
  logic             mwmem;
  logic             mm2reg;
  logic [AW-1:0]    a;
  logic [DW-1:0]    di;
  logic [DW-1:0]    do2;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_di;
  logic             m_we;
  logic             dbg_req;
  logic             dbg_we;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_wdata;
  logic             dbg_ack;
  logic [DW-1:0]    dbg_rdata;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  mwmem, mm2reg, a, di, do2, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output m_addr, m_di, m_we, dbg_ack, dbg_rdata, stall, stall_cnt
  );

  modport master (
    output mwmem, mm2reg, a, di, do2, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  m_addr, m_di, m_we, dbg_ack, dbg_rdata, stall, stall_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single datamem port between the MEM stage and a debug/loader port.
// Pipeline has priority; a blocked debug request is forced through after MAX_WAIT cycles.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam int unsigned WcW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

  state_e           state_q, state_d;
  logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic p_req;
  logic grant_dbg;
  logic stall;

  always_comb begin
    p_req     = bus.mwmem | bus.mm2reg;
    grant_dbg = bus.dbg_req & (state_q != StAck) &
                (~p_req | ((state_q == StPend) && (wait_cnt_q == WcW'(MAX_WAIT))));
    stall     = grant_dbg & p_req;
  end

  // The pipeline store is suppressed during a forced grant; EXEMEM is held so it retries.
  always_comb begin
    if (grant_dbg) begin
      bus.m_addr = bus.dbg_addr;
      bus.m_di   = bus.dbg_wdata;
      bus.m_we   = bus.dbg_we;
    end else begin
      bus.m_addr = bus.a;
      bus.m_di   = bus.di;
      bus.m_we   = bus.mwmem;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    stall_cnt_d = stall_cnt_q;

    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (grant_dbg) begin
      state_d    = StAck;
      ack_d      = 1'b1;
      wait_cnt_d = '0;
      if (!bus.dbg_we) begin
        rdata_d = bus.do2;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.dbg_req && p_req) begin
            state_d    = StPend;
            wait_cnt_d = WcW'(1);
          end
        end
        StPend: begin
          if (bus.dbg_req) begin
            wait_cnt_d = wait_cnt_q + WcW'(1);
          end else begin
            state_d    = StIdle;
            wait_cnt_d = '0;
          end
        end
        StAck: begin
          state_d = StIdle;
        end
        default: begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.dbg_ack   = ack_q;
  assign bus.dbg_rdata = rdata_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
